// File: rtl/ctrl_pkg.sv
// Shared encodings, control bundle and state type for the pipelined control unit.
package ctrl_pkg;

    localparam int unsigned OP_BASE_W   = 6;
    localparam int unsigned EXEC_BASE_W = 4;

    // Opcode map of the MIPS-subset core
    localparam logic [OP_BASE_W-1:0] OP_ADDU  = 6'h01;
    localparam logic [OP_BASE_W-1:0] OP_ADDI  = 6'h02;
    localparam logic [OP_BASE_W-1:0] OP_SUBIU = 6'h03;
    localparam logic [OP_BASE_W-1:0] OP_SLTI  = 6'h04;
    localparam logic [OP_BASE_W-1:0] OP_LUI   = 6'h05;
    localparam logic [OP_BASE_W-1:0] OP_DIV   = 6'h06;
    localparam logic [OP_BASE_W-1:0] OP_J     = 6'h07;
    localparam logic [OP_BASE_W-1:0] OP_JR    = 6'h08;
    localparam logic [OP_BASE_W-1:0] OP_BEQ   = 6'h09;
    localparam logic [OP_BASE_W-1:0] OP_LL    = 6'h0A;
    localparam logic [OP_BASE_W-1:0] OP_SC    = 6'h0B;

    // ALU command encodings
    localparam logic [EXEC_BASE_W-1:0] EXEC_NONE = 4'b0000;
    localparam logic [EXEC_BASE_W-1:0] EXEC_ADD  = 4'b0001;
    localparam logic [EXEC_BASE_W-1:0] EXEC_SUB  = 4'b0010;
    localparam logic [EXEC_BASE_W-1:0] EXEC_DIV  = 4'b0011;
    localparam logic [EXEC_BASE_W-1:0] EXEC_SLT  = 4'b0100;
    localparam logic [EXEC_BASE_W-1:0] EXEC_LUI  = 4'b0101;

    // Branch command encodings
    localparam logic [1:0] BC_NONE = 2'b00;
    localparam logic [1:0] BC_J    = 2'b01;
    localparam logic [1:0] BC_JR   = 2'b10;
    localparam logic [1:0] BC_BEQ  = 2'b11;

    typedef struct packed {
        logic [EXEC_BASE_W-1:0] exec;
        logic                   branch;
        logic [1:0]             branch_command;
        logic                   immediate_check;
        logic                   store_check;
        logic                   writeback;
        logic                   memory_read;
        logic                   memory_write;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational opcode-to-control-bundle table with illegal-opcode flag.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 6
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    output ctrl_bundle_t        bundle_c,
    output logic                illegal_c,
    output logic                is_div_c,
    output logic                is_ll_c,
    output logic                is_sc_c
);

    logic known;

    // Table lookup; unknown opcodes yield an all-zero bundle
    always_comb begin
        bundle_c  = '0;
        known     = 1'b1;
        is_div_c  = 1'b0;
        is_ll_c   = 1'b0;
        is_sc_c   = 1'b0;
        case (opcode)
            OPCODE_W'(OP_ADDU): begin
                bundle_c.exec      = EXEC_ADD;
                bundle_c.writeback = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                bundle_c.exec            = EXEC_ADD;
                bundle_c.writeback       = 1'b1;
                bundle_c.immediate_check = 1'b1;
            end
            OPCODE_W'(OP_SUBIU): begin
                bundle_c.exec            = EXEC_SUB;
                bundle_c.writeback       = 1'b1;
                bundle_c.immediate_check = 1'b1;
            end
            OPCODE_W'(OP_SLTI): begin
                bundle_c.exec            = EXEC_SLT;
                bundle_c.writeback       = 1'b1;
                bundle_c.immediate_check = 1'b1;
            end
            OPCODE_W'(OP_LUI): begin
                bundle_c.exec            = EXEC_LUI;
                bundle_c.writeback       = 1'b1;
                bundle_c.immediate_check = 1'b1;
                bundle_c.memory_read     = 1'b1;
                bundle_c.store_check     = 1'b1;
            end
            OPCODE_W'(OP_DIV): begin
                bundle_c.exec      = EXEC_DIV;
                bundle_c.writeback = 1'b1;
                is_div_c           = 1'b1;
            end
            OPCODE_W'(OP_J): begin
                bundle_c.immediate_check = 1'b1;
                bundle_c.branch          = 1'b1;
                bundle_c.branch_command  = BC_J;
            end
            OPCODE_W'(OP_JR): begin
                bundle_c.branch         = 1'b1;
                bundle_c.branch_command = BC_JR;
            end
            OPCODE_W'(OP_BEQ): begin
                bundle_c.immediate_check = 1'b1;
                bundle_c.branch          = 1'b1;
                bundle_c.branch_command  = BC_BEQ;
            end
            OPCODE_W'(OP_LL): begin
                bundle_c.exec            = EXEC_ADD;
                bundle_c.writeback       = 1'b1;
                bundle_c.immediate_check = 1'b1;
                bundle_c.memory_read     = 1'b1;
                bundle_c.store_check     = 1'b1;
                is_ll_c                  = 1'b1;
            end
            OPCODE_W'(OP_SC): begin
                bundle_c.exec            = EXEC_ADD;
                bundle_c.immediate_check = 1'b1;
                bundle_c.memory_write    = 1'b1;
                bundle_c.store_check     = 1'b1;
                is_sc_c                  = 1'b1;
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

    assign illegal_c = instr_valid & ~known;

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: registered decode into ID/EX with load-use stall,
// multi-cycle DIV sequencing, taken-branch flush window and LL/SC link tracking.
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W     = 6,
    parameter int unsigned EXEC_W       = 4,
    parameter int unsigned DIV_LATENCY  = 4,
    parameter int unsigned BRANCH_FLUSH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                instr_valid_i,
    input  logic                hazard_i,
    input  logic                branch_taken_i,
    input  logic                link_clear_i,
    output logic                branch,
    output logic [EXEC_W-1:0]   execute_command,
    output logic [1:0]          branch_command,
    output logic                immediate_check,
    output logic                store_check,
    output logic                writeback,
    output logic                memory_read,
    output logic                memory_write,
    output logic                ctrl_valid_o,
    output logic                stall_o,
    output logic                flush_o,
    output logic                illegal_o,
    output logic                link_valid_o,
    output logic                sc_success_o
);

    localparam int unsigned CNT_MAX = (DIV_LATENCY > BRANCH_FLUSH) ? DIV_LATENCY : BRANCH_FLUSH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Counter reloads: DIV waits DIV_LATENCY-1 cycles, flush holds BRANCH_FLUSH cycles after the pulse
    localparam logic [CNT_W-1:0] DIV_RELOAD   = CNT_W'((DIV_LATENCY > 1) ? (DIV_LATENCY - 2) : 0);
    localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(BRANCH_FLUSH - 1);

    ctrl_state_t  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_bundle_t bundle_q, bundle_d;
    logic         valid_q, valid_d;
    logic         illegal_q, illegal_d;
    logic         link_q, link_d;
    logic         sc_q, sc_d;
    logic         stall_c, flush_c;

    ctrl_bundle_t dec_bundle;
    logic         dec_illegal;
    logic         dec_div;
    logic         dec_ll;
    logic         dec_sc;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode      (opcode_i),
        .instr_valid (instr_valid_i),
        .bundle_c    (dec_bundle),
        .illegal_c   (dec_illegal),
        .is_div_c    (dec_div),
        .is_ll_c     (dec_ll),
        .is_sc_c     (dec_sc)
    );

    // Next-state, next-bundle and stall/flush; taken branch overrides everything
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bundle_d  = '0;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        sc_d      = 1'b0;
        link_d    = link_q;
        stall_c   = 1'b0;
        flush_c   = 1'b0;

        if (branch_taken_i) begin
            flush_c = 1'b1;
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_RELOAD;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    flush_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DIV_WAIT: begin
                    stall_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (instr_valid_i && hazard_i) begin
                        stall_c = 1'b1;
                    end else if (dec_illegal) begin
                        illegal_d = 1'b1;
                    end else if (instr_valid_i) begin
                        bundle_d = dec_bundle;
                        valid_d  = 1'b1;
                        if (dec_div && (DIV_LATENCY > 1)) begin
                            state_d = ST_DIV_WAIT;
                            cnt_d   = DIV_RELOAD;
                        end
                        if (dec_ll) begin
                            link_d = 1'b1;
                        end
                        // SC only stores if the reservation is still held
                        if (dec_sc) begin
                            sc_d                  = link_q;
                            bundle_d.memory_write = dec_bundle.memory_write & link_q;
                            link_d                = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        // External invalidation beats a same-cycle LL
        if (link_clear_i) begin
            link_d = 1'b0;
        end
    end

    // State, counter, link and ID/EX bundle registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            cnt_q     <= '0;
            bundle_q  <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            link_q    <= 1'b0;
            sc_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bundle_q  <= bundle_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            link_q    <= link_d;
            sc_q      <= sc_d;
        end
    end

    assign branch          = bundle_q.branch;
    assign execute_command = EXEC_W'(bundle_q.exec);
    assign branch_command  = bundle_q.branch_command;
    assign immediate_check = bundle_q.immediate_check;
    assign store_check     = bundle_q.store_check;
    assign writeback       = bundle_q.writeback;
    assign memory_read     = bundle_q.memory_read;
    assign memory_write    = bundle_q.memory_write;
    assign ctrl_valid_o    = valid_q;
    assign illegal_o       = illegal_q;
    assign link_valid_o    = link_q;
    assign sc_success_o    = sc_q;

    // Pipeline control is quiet while reset is held
    assign stall_o = stall_c & rst_n;
    assign flush_o = flush_c & rst_n;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit with default parameters.
module tb_pipelined_control_unit;

    localparam logic [5:0] T_ADDU  = 6'h01;
    localparam logic [5:0] T_ADDI  = 6'h02;
    localparam logic [5:0] T_SUBIU = 6'h03;
    localparam logic [5:0] T_SLTI  = 6'h04;
    localparam logic [5:0] T_LUI   = 6'h05;
    localparam logic [5:0] T_DIV   = 6'h06;
    localparam logic [5:0] T_J     = 6'h07;
    localparam logic [5:0] T_JR    = 6'h08;
    localparam logic [5:0] T_BEQ   = 6'h09;
    localparam logic [5:0] T_LL    = 6'h0A;
    localparam logic [5:0] T_SC    = 6'h0B;
    localparam logic [5:0] T_BAD   = 6'h3F;

    typedef struct packed {
        logic [11:0] bundle;
        logic        valid;
        logic        ill;
        logic        sc;
        logic        link;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode_i;
    logic       instr_valid_i;
    logic       hazard_i;
    logic       branch_taken_i;
    logic       link_clear_i;
    logic       branch;
    logic [3:0] execute_command;
    logic [1:0] branch_command;
    logic       immediate_check;
    logic       store_check;
    logic       writeback;
    logic       memory_read;
    logic       memory_write;
    logic       ctrl_valid_o;
    logic       stall_o;
    logic       flush_o;
    logic       illegal_o;
    logic       link_valid_o;
    logic       sc_success_o;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];

    pipelined_control_unit #(
        .OPCODE_W     (6),
        .EXEC_W       (4),
        .DIV_LATENCY  (4),
        .BRANCH_FLUSH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode_i        (opcode_i),
        .instr_valid_i   (instr_valid_i),
        .hazard_i        (hazard_i),
        .branch_taken_i  (branch_taken_i),
        .link_clear_i    (link_clear_i),
        .branch          (branch),
        .execute_command (execute_command),
        .branch_command  (branch_command),
        .immediate_check (immediate_check),
        .store_check     (store_check),
        .writeback       (writeback),
        .memory_read     (memory_read),
        .memory_write    (memory_write),
        .ctrl_valid_o    (ctrl_valid_o),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .illegal_o       (illegal_o),
        .link_valid_o    (link_valid_o),
        .sc_success_o    (sc_success_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference table: {exec[3:0], br, bc[1:0], imm, st, wb, mr, mw}
    function automatic logic [11:0] ref_decode(input logic [5:0] op);
        logic [3:0] e;
        logic [1:0] bc;
        logic br, imm, st, wb, mr, mw;
        e = 4'd0; bc = 2'd0; br = 0; imm = 0; st = 0; wb = 0; mr = 0; mw = 0;
        case (op)
            6'h01: begin e = 4'b0001; wb = 1; end
            6'h02: begin e = 4'b0001; wb = 1; imm = 1; end
            6'h03: begin e = 4'b0010; wb = 1; imm = 1; end
            6'h04: begin e = 4'b0100; wb = 1; imm = 1; end
            6'h05: begin e = 4'b0101; wb = 1; imm = 1; mr = 1; st = 1; end
            6'h06: begin e = 4'b0011; wb = 1; end
            6'h07: begin imm = 1; br = 1; bc = 2'b01; end
            6'h08: begin br = 1; bc = 2'b10; end
            6'h09: begin imm = 1; br = 1; bc = 2'b11; end
            6'h0A: begin e = 4'b0001; wb = 1; imm = 1; mr = 1; st = 1; end
            6'h0B: begin e = 4'b0001; imm = 1; mw = 1; st = 1; end
            default: ;
        endcase
        return {e, br, bc, imm, st, wb, mr, mw};
    endfunction

    function automatic logic [11:0] dut_bundle();
        return {execute_command, branch, branch_command, immediate_check,
                store_check, writeback, memory_read, memory_write};
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_empty", 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check("bundle",  32'(dut_bundle()),  32'(e.bundle));
            check("valid",   32'(ctrl_valid_o),  32'(e.valid));
            check("illegal", 32'(illegal_o),     32'(e.ill));
            check("sc",      32'(sc_success_o),  32'(e.sc));
            check("link",    32'(link_valid_o),  32'(e.link));
        end
    endtask

    // One pipeline cycle: drive, check combinational outputs, queue and check registered result
    task automatic step(input logic [5:0] op, input logic v, input logic h, input logic b,
                        input logic c, input logic e_stall, input logic e_flush,
                        input logic e_issue, input logic e_ill, input logic e_sc,
                        input logic e_link);
        exp_t e;
        opcode_i       = op;
        instr_valid_i  = v;
        hazard_i       = h;
        branch_taken_i = b;
        link_clear_i   = c;
        @(negedge clk);
        check("stall", 32'(stall_o), 32'(e_stall));
        check("flush", 32'(flush_o), 32'(e_flush));
        e.bundle = e_issue ? ref_decode(op) : 12'd0;
        if (e_issue && op == T_SC) e.bundle[0] = e_sc;
        e.valid = e_issue;
        e.ill   = e_ill;
        e.sc    = e_sc;
        e.link  = e_link;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bundle"}, 32'(dut_bundle()),   32'(0));
        check({tag, "_valid"},  32'(ctrl_valid_o),   32'(0));
        check({tag, "_ill"},    32'(illegal_o),      32'(0));
        check({tag, "_sc"},     32'(sc_success_o),   32'(0));
        check({tag, "_link"},   32'(link_valid_o),   32'(0));
        check({tag, "_stall"},  32'(stall_o),        32'(0));
        check({tag, "_flush"},  32'(flush_o),        32'(0));
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst_n          = 1'b0;
        opcode_i       = T_ADDI;
        instr_valid_i  = 1'b1;
        hazard_i       = 1'b1;
        branch_taken_i = 1'b1;
        link_clear_i   = 1'b0;
        #12;
        check_all_zero("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        //    op      v  h  b  c   stl fl iss ill sc lnk
        step(T_ADDI, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_LL,   1, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        step(T_SC,   1, 0, 0, 0,   0, 0, 1, 0, 1, 0);
        step(T_LL,   1, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        step(6'h00,  0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
        step(T_SC,   1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // DIV then three stall cycles while ADDU waits in ID
        step(T_DIV,  1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_ADDU, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step(T_ADDU, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step(T_ADDU, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
        step(T_ADDU, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // Load-use hazard holding LUI for two cycles
        step(T_LUI,  1, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        step(T_LUI,  1, 1, 0, 0,   1, 0, 0, 0, 0, 0);
        step(T_LUI,  1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // Link survives a branch that aborts DIV_WAIT
        step(T_LL,   1, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        step(T_DIV,  1, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        step(T_ADDU, 1, 0, 1, 0,   0, 1, 0, 0, 0, 1);
        step(T_ADDU, 1, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        step(T_ADDU, 1, 0, 0, 0,   0, 1, 0, 0, 0, 1);
        step(T_ADDU, 1, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        step(T_SC,   1, 0, 0, 0,   0, 0, 1, 0, 1, 0);
        // Illegal opcode pulse, then normal decode
        step(T_BAD,  1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
        step(T_ADDU, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // Hazard without a valid instruction does not stall
        step(T_ADDU, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0);
        step(T_J,    1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_JR,   1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_BEQ,  1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_SLTI, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_SUBIU,1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        // Simultaneous LL and clear: clear wins
        step(T_LL,   1, 0, 0, 1,   0, 0, 1, 0, 0, 0);
        step(T_SC,   1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
        step(T_LL,   1, 0, 0, 0,   0, 0, 1, 0, 0, 1);
        // Branch beats a hazard, then reset lands mid-FLUSH
        step(T_ADDU, 1, 1, 1, 0,   0, 1, 0, 0, 0, 1);
        opcode_i       = T_ADDU;
        instr_valid_i  = 1'b1;
        hazard_i       = 1'b0;
        branch_taken_i = 1'b0;
        rst_n          = 1'b0;
        #1;
        check_all_zero("midflush_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(T_ADDU, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Parametrised next-generation decode/control block for the 5-stage MIPS-subset core.
- Decodes the ID-stage opcode and registers the control bundle into the ID/EX boundary, giving one cycle of latency.
- Adds behaviour the combinational decoder lacks:
  - load-use bubble insertion with a fetch stall,
  - multi-cycle DIV sequencing,
  - branch-taken flush windows,
  - LL/SC link tracking,
  - illegal-opcode flagging.

Parameters:
- OPCODE_W, 6, opcode field width.
- EXEC_W, 4, width of execute_command.
- DIV_LATENCY, 4, total EX cycles for DIV (>=1); 1 means no wait state.
- BRANCH_FLUSH, 2, bubbles inserted after a taken branch (>=1).
- CNT_W, derived localparam = clog2(max(DIV_LATENCY, BRANCH_FLUSH)+1).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode_i  in  OPCODE_W  opcode of the instruction in ID.
- instr_valid_i  in  1  ID holds a real instruction.
- hazard_i  in  1  load-use hazard detected for the ID instruction.
- branch_taken_i  in  1  EX resolved a taken branch/jump this cycle.
- link_clear_i  in  1  external invalidation of the LL reservation.
- branch  out  1  registered.
- execute_command  out  EXEC_W  registered ALU op.
- branch_command  out  2  01 J, 10 JR, 11 BEQ.
- immediate_check, store_check, writeback, memory_read, memory_write  out  1 each  registered.
- ctrl_valid_o  out  1  registered bundle is a real instruction.
- stall_o  out  1  combinational; hold PC and IF/ID.
- flush_o  out  1  combinational; squash IF/ID.
- illegal_o  out  1  registered, one-cycle pulse.
- link_valid_o  out  1  LL reservation held.
- sc_success_o  out  1  registered with an SC bundle; 1 = store proceeds.

Behaviour:
- Reset: all registered outputs 0, state RUN, counter 0, link_valid_o 0. stall_o and flush_o are 0 during reset.
- Decode table (package constants):
  - ADDU 01: exec 0001, wb.
  - ADDI 02: exec 0001, wb, imm.
  - SUBIU 03: exec 0010, wb, imm.
  - SLTI 04: exec 0100, wb, imm.
  - LUI 05: exec 0101, wb, imm, mr, st.
  - DIV 06: exec 0011, wb.
  - J 07: imm, br, bc 01.
  - JR 08: br, bc 10.
  - BEQ 09: imm, br, bc 11.
  - LL 0A: exec 0001, wb, imm, mr, st.
  - SC 0B: exec 0001, imm, mw, st.
  - exec is zero-extended to EXEC_W.
- Bubble: every bundle bit 0 and ctrl_valid_o 0.
- States:
  - RUN: normal decode.
  - DIV_WAIT: count down DIV_LATENCY-1 cycles.
  - FLUSH: count down BRANCH_FLUSH cycles.
- Priority each cycle: branch_taken_i > DIV_WAIT/FLUSH countdown > hazard_i > decode.
- branch_taken_i=1, any state:
  - flush_o=1 this cycle; next cycle's bundle is a bubble.
  - Enter FLUSH with counter = BRANCH_FLUSH-1. An in-progress DIV_WAIT is aborted.
- FLUSH:
  - flush_o=1, bubbles each cycle.
  - Return to RUN when the counter reaches 0; the instruction present then decodes on the next cycle.
  - A new branch_taken_i reloads the counter.
- RUN, hazard_i=1 with instr_valid_i=1:
  - stall_o=1 combinational; next bundle is a bubble.
  - Upstream holds opcode_i; the instruction decodes once hazard_i drops.
- RUN, instr_valid_i=0: bubble; no stall.
- RUN, DIV accepted:
  - DIV bundle registered.
  - If DIV_LATENCY>1: enter DIV_WAIT with counter = DIV_LATENCY-2, stall_o=1, bubbles.
  - RUN resumes after the counter reaches 0, giving exactly DIV_LATENCY-1 stall cycles.
- Unknown opcode with instr_valid_i=1: bubble; illegal_o=1 for one cycle.
- LL/SC link tracking:
  - LL issue sets link_valid.
  - SC issue: sc_success_o = link_valid at issue, memory_write = memory_write & link_valid, and link_valid is cleared.
  - link_clear_i clears link_valid the next cycle. Simultaneous LL issue and link_clear_i: clear wins.
  - Taken-branch flush does not clear the link.
- Reset asserted mid-DIV_WAIT or mid-FLUSH: immediate return to reset values.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams,
  - EXEC_* command encodings,
  - BC_* branch_command encodings,
  - the packed control-bundle typedef,
  - the state enum.
- One sub-module: ctrl_decode. It is the pure combinational opcode-to-bundle table plus the illegal flag, and is instantiated by pipelined_control_unit, which owns the state, counter, link and registers.

Test Plan:
- Reset release, then ADDI(02) valid -> next cycle exec=0001, wb=1, imm=1, ctrl_valid_o=1; all outputs 0 during reset.
- LL(0A) then SC(0B) -> SC bundle memory_write=1, sc_success_o=1, link_valid_o=0 after. Repeat with link_clear_i between the two -> memory_write=0, sc_success_o=0.
- DIV(06) with DIV_LATENCY=4 -> DIV bundle, then stall_o=1 for 3 cycles with bubbles, then the following ADDU decodes.
- hazard_i high for 2 cycles with LUI held -> stall_o=1 and two bubbles, then LUI bundle with mr=1, st=1.
- branch_taken_i pulse with BRANCH_FLUSH=2, including during DIV_WAIT -> flush_o=1 for 3 consecutive cycles (pulse + 2) and bubbles, DIV_WAIT aborted, then decode resumes.
- opcode 3F valid -> bubble, illegal_o single-cycle pulse. Reset asserted mid-FLUSH -> all outputs 0 and state RUN.
